// File: rtl/pipe_ctrl.sv
// pipe_ctrl: sequencing controller for a 5-stage in-order core.
// Owns the fetch PC. Each cycle it decides whether decode issues, stalls or is flushed.
// A three-entry scoreboard (EX/MEM/WB) tracks in-flight destination registers and stalls
// decode on read-after-write hazards. A taken branch/jump reported from EX redirects fetch.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   dec_valid                decode holds a valid instruction
//   dec_rs1_v/dec_rs1        rs1 source enable and index
//   dec_rs2_v/dec_rs2        rs2 source enable and index
//   dec_rd_v/dec_rd          destination enable and index
//   redirect_v/redirect_pc   taken control transfer from EX and its target
//   pc                       registered fetch address
//   fetch_en                 fetch->decode register may load
//   issue_v                  decode->exec register loads a real instruction
//   flush                    clear fetch->decode and decode->exec valids
//   stall                    RAW hazard this cycle
//   stall_cnt                saturating count of stall cycles
module pipe_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter bit          WB_BYPASS = 1'b0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic             dec_rs1_v,
  input  logic [4:0]       dec_rs1,
  input  logic             dec_rs2_v,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_rd_v,
  input  logic [4:0]       dec_rd,
  input  logic             redirect_v,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      pc,
  output logic             fetch_en,
  output logic             issue_v,
  output logic             flush,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ex_v_q, mem_v_q, wb_v_q;
  logic [4:0]       ex_rd_q, mem_rd_q, wb_rd_q;
  logic             ex_v_d;
  logic             rs1_hit, rs2_hit;

  // With a write-first regfile the WB writer is visible to decode, so WB cannot hazard.
  assign rs1_hit = dec_rs1_v && (dec_rs1 != 5'd0) &&
                   ((ex_v_q && (ex_rd_q == dec_rs1)) ||
                    (mem_v_q && (mem_rd_q == dec_rs1)) ||
                    (!WB_BYPASS && wb_v_q && (wb_rd_q == dec_rs1)));
  assign rs2_hit = dec_rs2_v && (dec_rs2 != 5'd0) &&
                   ((ex_v_q && (ex_rd_q == dec_rs2)) ||
                    (mem_v_q && (mem_rd_q == dec_rs2)) ||
                    (!WB_BYPASS && wb_v_q && (wb_rd_q == dec_rs2)));

  // A redirect squashes the younger instruction in decode, so it also masks its hazard.
  assign stall     = dec_valid && !redirect_v && (rs1_hit || rs2_hit);
  assign issue_v   = dec_valid && !stall && !redirect_v;
  assign fetch_en  = !stall;
  assign flush     = redirect_v;
  assign pc        = pc_q;
  assign stall_cnt = cnt_q;

  // x0 writes are not tracked: they can never produce a hazard.
  assign ex_v_d = issue_v && dec_rd_v && (dec_rd != 5'd0);

  always_comb begin
    pc_d = pc_q + 32'd4;
    if (redirect_v) begin
      pc_d = redirect_pc;
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      ex_v_q   <= 1'b0;
      mem_v_q  <= 1'b0;
      wb_v_q   <= 1'b0;
      ex_rd_q  <= 5'd0;
      mem_rd_q <= 5'd0;
      wb_rd_q  <= 5'd0;
    end else begin
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      ex_v_q   <= ex_v_d;
      ex_rd_q  <= dec_rd;
      mem_v_q  <= ex_v_q;
      mem_rd_q <= ex_rd_q;
      wb_v_q   <= mem_v_q;
      wb_rd_q  <= mem_rd_q;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl. The reference model keeps a short history of the
// destination registers issued in the last three cycles and derives hazards, PC and the
// stall count from that history.
module tb_pipe_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_1000;
  localparam int          CNT_W    = 6;
  localparam int          MAXC     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             dec_valid, dec_rs1_v, dec_rs2_v, dec_rd_v, redirect_v;
  logic [4:0]       dec_rs1, dec_rs2, dec_rd;
  logic [31:0]      redirect_pc;
  logic [31:0]      pc;
  logic             fetch_en, issue_v, flush, stall;
  logic [CNT_W-1:0] stall_cnt;

  pipe_ctrl #(
    .RESET_PC (RESET_PC),
    .WB_BYPASS(1'b0),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dec_valid  (dec_valid),
    .dec_rs1_v  (dec_rs1_v),
    .dec_rs1    (dec_rs1),
    .dec_rs2_v  (dec_rs2_v),
    .dec_rs2    (dec_rs2),
    .dec_rd_v   (dec_rd_v),
    .dec_rd     (dec_rd),
    .redirect_v (redirect_v),
    .redirect_pc(redirect_pc),
    .pc         (pc),
    .fetch_en   (fetch_en),
    .issue_v    (issue_v),
    .flush      (flush),
    .stall      (stall),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: hist[0] = rd issued last cycle (0 = nothing tracked).
  logic [31:0] m_pc;
  logic [4:0]  hist [3];
  int          m_total;
  logic        e_stall, e_issue, e_fetch, e_flush;

  function automatic bit in_flight(input logic [4:0] r);
    // Last three issues are visible to decode (no WB bypass).
    return (r != 5'd0) && (hist[0] == r || hist[1] == r || hist[2] == r);
  endfunction

  function automatic logic [CNT_W-1:0] e_cnt();
    return (m_total > MAXC) ? CNT_W'(MAXC) : CNT_W'(m_total);
  endfunction

  task automatic set_in(input logic dv, input logic r1v, input logic [4:0] r1,
                        input logic r2v, input logic [4:0] r2, input logic rdv,
                        input logic [4:0] rd, input logic rv, input logic [31:0] rpc);
    dec_valid = dv; dec_rs1_v = r1v; dec_rs1 = r1; dec_rs2_v = r2v; dec_rs2 = r2;
    dec_rd_v = rdv; dec_rd = rd; redirect_v = rv; redirect_pc = rpc;
    e_stall = dv && !rv && ((r1v && in_flight(r1)) || (r2v && in_flight(r2)));
    e_issue = dv && !rv && !e_stall;
    e_fetch = !e_stall;
    e_flush = rv;
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_pc = RESET_PC; m_total = 0;
      hist[0] = 5'd0; hist[1] = 5'd0; hist[2] = 5'd0;
    end else begin
      if (redirect_v) m_pc = redirect_pc;
      else if (!e_stall) m_pc = m_pc + 32'd4;
      if (e_stall) m_total++;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = (e_issue && dec_rd_v) ? dec_rd : 5'd0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if (pc !== RESET_PC) begin
      n_bad++; $display("FAIL reset_pc got %h want %h", pc, RESET_PC);
    end
    n_cmp++;
    if (stall_cnt !== '0) begin
      n_bad++; $display("FAIL reset_cnt got %0d want 0", stall_cnt);
    end
    set_in(1'b1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 32'h0);
    n_cmp++;
    if (stall !== 1'b0 || issue_v !== 1'b1) begin
      n_bad++; $display("FAIL reset_first got stall=%b issue=%b want 0/1", stall, issue_v);
    end
    tick();
  endtask

  task automatic test_no_hazard();
    logic [31:0] base;
    base = pc;
    for (int i = 1; i <= 8; i++) begin
      set_in(1'b1, 1'b0, 5'($urandom), 1'b0, 5'($urandom), 1'b1, 5'($urandom), 1'b0, 32'h0);
      n_cmp++;
      if (stall !== 1'b0 || issue_v !== 1'b1 || fetch_en !== 1'b1) begin
        n_bad++;
        $display("FAIL nohaz_comb got stall=%b issue=%b fe=%b want 0/1/1", stall, issue_v,
                 fetch_en);
      end
      tick();
      n_cmp++;
      if (pc !== base + 32'(4 * i)) begin
        n_bad++; $display("FAIL nohaz_pc got %h want %h", pc, base + 32'(4 * i));
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin idle(); tick(); end
  endtask

  task automatic test_raw_stall();
    logic [31:0]      hold_pc;
    logic [CNT_W-1:0] cnt0;
    int               stalls;
    drain();
    cnt0 = stall_cnt;
    set_in(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 32'h0);
    tick();
    hold_pc = pc;
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd6, 1'b0, 32'h0);
      n_cmp++;
      if (stall !== e_stall || issue_v !== e_issue) begin
        n_bad++;
        $display("FAIL raw_comb got stall=%b issue=%b want %b/%b", stall, issue_v, e_stall,
                 e_issue);
      end
      if (!stall) break;
      stalls++;
      tick();
      n_cmp++;
      if (pc !== hold_pc) begin
        n_bad++; $display("FAIL raw_hold got %h want %h", pc, hold_pc);
      end
    end
    n_cmp++;
    if (stalls !== 3) begin
      n_bad++; $display("FAIL raw_len got %0d want 3", stalls);
    end
    n_cmp++;
    if (issue_v !== 1'b1) begin
      n_bad++; $display("FAIL raw_release got %b want 1", issue_v);
    end
    n_cmp++;
    if (stall_cnt !== cnt0 + CNT_W'(3)) begin
      n_bad++; $display("FAIL raw_cnt got %0d want %0d", stall_cnt, cnt0 + CNT_W'(3));
    end
    tick();
  endtask

  task automatic test_x0_rsv();
    drain();
    set_in(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 32'h0);
    tick();
    set_in(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++; $display("FAIL x0_hazard got %b want 0", stall);
    end
    tick();
    set_in(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 32'h0);
    tick();
    set_in(1'b1, 1'b0, 5'd7, 1'b0, 5'd7, 1'b0, 5'd0, 1'b0, 32'h0);
    n_cmp++;
    if (stall !== 1'b0 || issue_v !== 1'b1) begin
      n_bad++; $display("FAIL rsv0 got stall=%b issue=%b want 0/1", stall, issue_v);
    end
    tick();
  endtask

  task automatic test_redirect_stall();
    drain();
    set_in(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 32'h0);
    tick();
    set_in(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, 32'h0);
    n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++; $display("FAIL redir_prestall got %b want 1", stall);
    end
    tick();
    set_in(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 5'd8, 1'b1, 32'h100);
    n_cmp++;
    if (flush !== 1'b1 || issue_v !== 1'b0 || stall !== 1'b0) begin
      n_bad++;
      $display("FAIL redir_comb got flush=%b issue=%b stall=%b want 1/0/0", flush, issue_v,
               stall);
    end
    tick();
    n_cmp++;
    if (pc !== 32'h100) begin
      n_bad++; $display("FAIL redir_pc got %h want 00000100", pc);
    end
    drain();
  endtask

  task automatic test_pc_wrap();
    set_in(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 32'hFFFF_FFFC);
    tick();
    n_cmp++;
    if (pc !== 32'hFFFF_FFFC) begin
      n_bad++; $display("FAIL wrap_set got %h want fffffffc", pc);
    end
    idle();
    tick();
    n_cmp++;
    if (pc !== 32'h0) begin
      n_bad++; $display("FAIL wrap got %h want 00000000", pc);
    end
  endtask

  task automatic test_saturation();
    int start, guard;
    drain();
    start = m_total;
    guard = 0;
    while (m_total - start < MAXC + 1 + 5 && guard < 400) begin
      set_in(1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 32'h0);
      tick();
      guard++;
      n_cmp++;
      if (stall_cnt !== e_cnt()) begin
        n_bad++; $display("FAIL sat_track got %0d want %0d", stall_cnt, e_cnt());
      end
    end
    n_cmp++;
    if (guard >= 400) begin
      n_bad++; $display("FAIL sat_budget got %0d stalls want %0d", m_total - start, MAXC + 6);
    end
    n_cmp++;
    if (stall_cnt !== {CNT_W{1'b1}}) begin
      n_bad++; $display("FAIL sat_final got %0d want %0d", stall_cnt, MAXC);
    end
  endtask

  task automatic test_reset_mid();
    drain();
    set_in(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 32'h0);
    tick();
    set_in(1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 5'd2, 1'b0, 32'h0);
    n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_pre got %b want 1", stall);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_in(1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 5'd2, 1'b0, 32'h0);
    n_cmp++;
    if (stall !== 1'b0 || pc !== RESET_PC || stall_cnt !== '0) begin
      n_bad++;
      $display("FAIL rstmid got stall=%b pc=%h cnt=%0d want 0/%h/0", stall, pc, stall_cnt,
               RESET_PC);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      set_in($urandom_range(0, 7) != 0, 1'($urandom), 5'($urandom_range(0, 7)),
             1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
             5'($urandom_range(0, 7)), $urandom_range(0, 9) == 0, $urandom & 32'hFFFF_FFFC);
      n_cmp++;
      if (stall !== e_stall || issue_v !== e_issue || fetch_en !== e_fetch ||
          flush !== e_flush) begin
        n_bad++;
        $display("FAIL rand_comb got s=%b i=%b f=%b fl=%b want %b/%b/%b/%b", stall, issue_v,
                 fetch_en, flush, e_stall, e_issue, e_fetch, e_flush);
      end
      tick();
      n_cmp++;
      if (pc !== m_pc || stall_cnt !== e_cnt()) begin
        n_bad++;
        $display("FAIL rand_state got pc=%h cnt=%0d want %h/%0d", pc, stall_cnt, m_pc, e_cnt());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    m_pc = RESET_PC; m_total = 0;
    hist[0] = 5'd0; hist[1] = 5'd0; hist[2] = 5'd0;
    rst = 1'b1;
    idle();
    test_reset();
    test_no_hazard();
    test_raw_stall();
    test_x0_rsv();
    test_redirect_stall();
    test_pc_wrap();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
